// File: rtl/rx_flow_pkg.sv
// rtl/rx_flow_pkg.sv - shared flow-control characters and FSM state type
package rx_flow_pkg;

  localparam logic [7:0] XON_CHAR  = 8'h11;
  localparam logic [7:0] XOFF_CHAR = 8'h13;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SEND_XOFF = 2'd1,
    PAUSED    = 2'd2,
    SEND_XON  = 2'd3
  } flow_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through storage with occupancy count
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage is left unreset; only written on an accepted push.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/rx_flow_fifo.sv
// rtl/rx_flow_fifo.sv - receive FIFO with XON/XOFF flow control and sticky overflow
module rx_flow_fifo
  import rx_flow_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int XOFF_LEVEL = 12,
  parameter int XON_LEVEL  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  input  logic                   i_clr_overflow,
  output logic                   o_paused
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] XOFF_CNT = CW'(XOFF_LEVEL);
  localparam logic [CW-1:0] XON_CNT  = CW'(XON_LEVEL);

  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic          push;
  logic          drop;
  logic          overflow_q, overflow_d;
  flow_state_t   state_q, state_d;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = !fifo_empty && i_ready;
  assign push = i_valid && (!fifo_full || pop);
  assign drop = i_valid && fifo_full && !pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_sync_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_wdata (i_data),
    .o_rdata (o_data),
    .o_count (fifo_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (i_clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Flow FSM next state and transmit outputs, thresholds on registered count.
  always_comb begin
    state_d    = state_q;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_paused   = 1'b0;
    case (state_q)
      RUN: begin
        if (fifo_count >= XOFF_CNT) begin
          state_d = SEND_XOFF;
        end
      end
      SEND_XOFF: begin
        o_tx_valid = 1'b1;
        o_tx_data  = XOFF_CHAR;
        if (i_tx_ready) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        o_paused = 1'b1;
        if (fifo_count <= XON_CNT) begin
          state_d = SEND_XON;
        end
      end
      SEND_XON: begin
        o_paused   = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = XON_CHAR;
        if (i_tx_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Flow state and overflow flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_valid    = !fifo_empty;
  assign o_count    = fifo_count;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_rx_flow_fifo.sv
// tb/tb_rx_flow_fifo.sv - directed self-checking bench for rx_flow_fifo
module tb_rx_flow_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       i_clr_overflow;
  logic       o_paused;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs [7];

  always #5 i_clk = ~i_clk;

  rx_flow_fifo #(
    .DEPTH      (16),
    .XOFF_LEVEL (12),
    .XON_LEVEL  (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .i_clr_overflow (i_clr_overflow),
    .o_paused       (o_paused)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid        = 1'b0;
    i_ready        = 1'b0;
    i_clr_overflow = 1'b0;
    i_data         = 8'h00;
  endtask

  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_tx_ready = 1'b0;
    idle();
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    exp_q.push_back(d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic pop_byte(input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(name, {31'd0, o_valid}, 32'd1);
    check(name, {24'd0, o_data}, {24'd0, e});
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{valid: 1'b1, data: 8'h41, ready: 1'b0, e_count: 5'd1, e_valid: 1'b1, e_data: 8'h41};
    vecs[1] = '{valid: 1'b1, data: 8'h42, ready: 1'b0, e_count: 5'd2, e_valid: 1'b1, e_data: 8'h41};
    vecs[2] = '{valid: 1'b0, data: 8'h00, ready: 1'b1, e_count: 5'd1, e_valid: 1'b1, e_data: 8'h42};
    vecs[3] = '{valid: 1'b0, data: 8'h00, ready: 1'b1, e_count: 5'd0, e_valid: 1'b0, e_data: 8'h00};
    vecs[4] = '{valid: 1'b1, data: 8'h50, ready: 1'b1, e_count: 5'd1, e_valid: 1'b1, e_data: 8'h50};
    vecs[5] = '{valid: 1'b1, data: 8'h51, ready: 1'b1, e_count: 5'd1, e_valid: 1'b1, e_data: 8'h51};
    vecs[6] = '{valid: 1'b0, data: 8'h00, ready: 1'b1, e_count: 5'd0, e_valid: 1'b0, e_data: 8'h00};

    do_reset();
    check("rst_count",    {27'd0, o_count}, 32'd0);
    check("rst_valid",    {31'd0, o_valid}, 32'd0);
    check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    check("rst_tx_data",  {24'd0, o_tx_data}, 32'd0);
    check("rst_paused",   {31'd0, o_paused}, 32'd0);
    check("rst_overflow", {31'd0, o_overflow}, 32'd0);

    // Basic push/pop vectors
    for (int i = 0; i < 7; i++) begin
      i_valid = vecs[i].valid;
      i_data  = vecs[i].data;
      i_ready = vecs[i].ready;
      if (vecs[i].valid && i_rst_n) begin
        if (o_count == 5'd0) check($sformatf("vec%0d_no_bypass", i), {31'd0, o_valid}, 32'd0);
      end
      tick();
      check($sformatf("vec%0d_count", i), {27'd0, o_count}, {27'd0, vecs[i].e_count});
      check($sformatf("vec%0d_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_data", i), {24'd0, o_data}, {24'd0, vecs[i].e_data});
      end
    end
    idle();

    // XOFF after twelfth push, one cycle of latency
    do_reset();
    i_tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) push_byte(8'(8'h60 + i));
    check("xoff_count12", {27'd0, o_count}, 32'd12);
    check("xoff_latency", {31'd0, o_tx_valid}, 32'd0);
    tick();
    check("xoff_valid",  {31'd0, o_tx_valid}, 32'd1);
    check("xoff_data",   {24'd0, o_tx_data}, 32'h13);
    check("xoff_unpaus", {31'd0, o_paused}, 32'd0);
    tick();
    check("paused_set",   {31'd0, o_paused}, 32'd1);
    check("paused_txv",   {31'd0, o_tx_valid}, 32'd0);
    check("paused_txd",   {24'd0, o_tx_data}, 32'd0);

    // Fill to full, then overflow and clear
    for (int i = 12; i < 16; i++) push_byte(8'(8'h60 + i));
    check("full_count", {27'd0, o_count}, 32'd16);
    i_valid = 1'b1;
    i_data  = 8'hFF;
    tick();
    check("ovf_count", {27'd0, o_count}, 32'd16);
    check("ovf_set",   {31'd0, o_overflow}, 32'd1);
    check("ovf_head",  {24'd0, o_data}, 32'h60);
    i_clr_overflow = 1'b1;
    tick();
    check("ovf_set_wins", {31'd0, o_overflow}, 32'd1);
    i_valid = 1'b0;
    tick();
    check("ovf_cleared", {31'd0, o_overflow}, 32'd0);
    idle();

    // Push and pop together while full
    for (int k = 0; k < 2; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("pp_head", {24'd0, o_data}, {24'd0, e});
      i_valid = 1'b1;
      i_ready = 1'b1;
      i_data  = 8'(8'h80 + k);
      exp_q.push_back(i_data);
      tick();
      check("pp_count", {27'd0, o_count}, 32'd16);
      check("pp_no_ovf", {31'd0, o_overflow}, 32'd0);
    end
    idle();

    // Drain to the XON level, hold the transmitter off
    i_tx_ready = 1'b0;
    for (int i = 0; i < 12; i++) pop_byte("drain_order");
    check("xon_count4", {27'd0, o_count}, 32'd4);
    check("xon_latency", {31'd0, o_tx_valid}, 32'd0);
    tick();
    check("xon_valid", {31'd0, o_tx_valid}, 32'd1);
    check("xon_data",  {24'd0, o_tx_data}, 32'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("xon_hold_valid",  {31'd0, o_tx_valid}, 32'd1);
      check("xon_hold_data",   {24'd0, o_tx_data}, 32'h11);
      check("xon_hold_paused", {31'd0, o_paused}, 32'd1);
    end
    i_tx_ready = 1'b1;
    tick();
    check("run_paused", {31'd0, o_paused}, 32'd0);
    check("run_txv",    {31'd0, o_tx_valid}, 32'd0);
    for (int i = 0; i < 4; i++) pop_byte("wrap_order");
    check("empty_count", {27'd0, o_count}, 32'd0);
    check("empty_valid", {31'd0, o_valid}, 32'd0);

    // Reset during a pending XOFF
    do_reset();
    for (int i = 0; i < 12; i++) push_byte(8'(8'hA0 + i));
    tick();
    check("pend_xoff", {31'd0, o_tx_valid}, 32'd1);
    i_ready = 1'b1;
    repeat (6) tick();
    i_ready = 1'b0;
    check("pend_count6",  {27'd0, o_count}, 32'd6);
    check("pend_kept_v",  {31'd0, o_tx_valid}, 32'd1);
    check("pend_kept_d",  {24'd0, o_tx_data}, 32'h13);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_txv",    {31'd0, o_tx_valid}, 32'd0);
    check("arst_txd",    {24'd0, o_tx_data}, 32'd0);
    check("arst_count",  {27'd0, o_count}, 32'd0);
    check("arst_valid",  {31'd0, o_valid}, 32'd0);
    check("arst_paused", {31'd0, o_paused}, 32'd0);
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_txv", {31'd0, o_tx_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_flow_fifo.md
RX_FLOW_FIFO -- requirements
Module: rx_flow_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 4 to 256.
REQ-002 Parameter XOFF_LEVEL, default 12, occupancy at which XOFF is requested.
REQ-003 Parameter XON_LEVEL, default 4, occupancy at which XON is requested; SHALL be less than XOFF_LEVEL.
REQ-004 i_clk  in  1  single clock, all logic on posedge (pixel clock domain).
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_data  in  8  received byte from the UART receiver.
REQ-007 i_valid  in  1  one-cycle strobe, push i_data; no backpressure toward the receiver.
REQ-008 o_data  out  8  head byte to the display core.
REQ-009 o_valid  out  1  head byte present.
REQ-010 i_ready  in  1  consumer accepts head byte.
REQ-011 o_tx_data  out  8  flow-control byte to the UART transmitter.
REQ-012 o_tx_valid  out  1  flow-control byte pending.
REQ-013 i_tx_ready  in  1  transmitter accepts o_tx_data.
REQ-014 o_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 o_overflow  out  1  sticky flag, byte dropped.
REQ-016 i_clr_overflow  in  1  clears o_overflow.
REQ-017 o_paused  out  1  high from XOFF acceptance until XON acceptance.

Function
REQ-018 Push SHALL occur when i_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-019 Pop SHALL occur when o_valid=1 and i_ready=1.
REQ-020 The FIFO SHALL be first-word-fall-through: o_data=mem[rd_ptr]; o_valid=(count!=0).
REQ-021 A byte pushed into an empty FIFO SHALL appear on o_valid/o_data exactly one cycle after the push cycle; there is no combinational bypass.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL increment on push-only, decrement on pop-only, and hold on push+pop.
REQ-023 i_valid while full with no pop SHALL drop the byte, leave memory and count unchanged, and set o_overflow the next cycle.
REQ-024 o_overflow SHALL clear on i_clr_overflow=1; if overflow and clear coincide, set SHALL win.
REQ-025 Flow FSM states: RUN, SEND_XOFF, PAUSED, SEND_XON.
REQ-026 RUN: count>=XOFF_LEVEL -> SEND_XOFF.
REQ-027 SEND_XOFF: o_tx_valid=1, o_tx_data=8'h13; i_tx_ready=1 -> PAUSED.
REQ-028 PAUSED: count<=XON_LEVEL -> SEND_XON.
REQ-029 SEND_XON: o_tx_valid=1, o_tx_data=8'h11; i_tx_ready=1 -> RUN.
REQ-030 In SEND_* states, o_tx_data SHALL remain stable until accepted; a pending XOFF SHALL NOT be cancelled if count falls meanwhile.
REQ-031 o_tx_valid SHALL be 0 in RUN and PAUSED; o_tx_data SHALL be 8'h00 when o_tx_valid=0.
REQ-032 FSM thresholds SHALL use registered count, giving one cycle of latency from the push to SEND_XOFF.
REQ-033 o_paused SHALL be 1 in PAUSED and SEND_XON, and 0 otherwise.

Reset
REQ-034 On i_rst_n=0, the block SHALL asynchronously clear pointers, count, o_overflow, and FSM (to RUN); o_valid=0, o_tx_valid=0, o_tx_data=0, o_paused=0.
REQ-035 Memory contents SHALL NOT require reset; o_data is don't-care while o_valid=0.
REQ-036 Reset mid-transfer SHALL abandon any pending XON/XOFF; no byte is emitted after release until thresholds are crossed anew.

Structure
REQ-037 Package rx_flow_pkg SHALL hold XON_CHAR=8'h11, XOFF_CHAR=8'h13, and the flow_state_t enum.
REQ-038 Storage/pointer logic SHALL be a sub-module sync_fifo (DEPTH, WIDTH=8); the FSM and overflow logic SHALL live in rx_flow_fifo.

Verification
REQ-039 Reset, push 8'h41, 8'h42 with i_ready=0 -> o_count=2, o_data=8'h41; i_ready=1 for 2 cycles -> 41 then 42 out, o_valid=0, count=0.
REQ-040 Push 12 bytes, i_ready=0, i_tx_ready=1 -> o_tx_valid=1 with 8'h13 within 2 cycles of 12th push, o_paused=1 after acceptance.
REQ-041 Continue to 16, push 8'hFF -> byte dropped, o_count=16, o_overflow=1; pulse i_clr_overflow -> 0.
REQ-042 Drain from 16 to 4 -> 8'h11 offered, i_tx_ready held 0 for 5 cycles -> data stable, then accepted, FSM RUN, o_paused=0.
REQ-043 Full FIFO, push+pop same cycle -> count stays 16, no overflow, order preserved across pointer wrap.
REQ-044 Assert i_rst_n=0 during SEND_XOFF with i_tx_ready=0 -> o_tx_valid=0 immediately, count=0, no XOFF after release.
